// File: rtl/spmv_ctrl_pkg.sv
// Shared constants for the SpMV AXI4-Lite control/status register block.
package spmv_ctrl_pkg;

  localparam int unsigned AXIL_AW = 32;
  localparam int unsigned AXIL_DW = 32;
  localparam int unsigned DEC_W   = 8;

  localparam logic [DEC_W-1:0] REG_CTRL      = 8'h00;
  localparam logic [DEC_W-1:0] REG_ROW_NUM   = 8'h04;
  localparam logic [DEC_W-1:0] REG_VEC_BASE  = 8'h08;
  localparam logic [DEC_W-1:0] REG_STATUS    = 8'h0C;
  localparam logic [DEC_W-1:0] REG_CYCLE_CNT = 8'h10;

  localparam logic [AXIL_DW-1:0] SOFT_RST_KEY = 32'hAA;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/spmv_axil_ctrl_slave.sv
// AXI4-Lite responder for SpMV engine control: config registers, start/soft-reset
// generation, and per-kernel completion / busy-cycle tracking.
module spmv_axil_ctrl_slave
  import spmv_ctrl_pkg::*;
#(
  parameter int unsigned CONF_NUM_KERNEL = 4,
  parameter int unsigned SOFT_RST_CYCLES = 16
) (
  input  logic                       axil_clk,
  input  logic                       rst,
  input  logic                       s_axil_awvalid,
  input  logic [AXIL_AW-1:0]         s_axil_awaddr,
  output logic                       s_axil_awready,
  input  logic                       s_axil_wvalid,
  input  logic [AXIL_DW-1:0]         s_axil_wdata,
  output logic                       s_axil_wready,
  output logic                       s_axil_bvalid,
  output logic [1:0]                 s_axil_bresp,
  input  logic                       s_axil_bready,
  input  logic                       s_axil_arvalid,
  input  logic [AXIL_AW-1:0]         s_axil_araddr,
  output logic                       s_axil_arready,
  output logic                       s_axil_rvalid,
  output logic [AXIL_DW-1:0]         s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  input  logic                       s_axil_rready,
  output logic [6:0]                 cfg_mode,
  output logic [AXIL_DW-1:0]         cfg_row_num,
  output logic [AXIL_DW-1:0]         cfg_vec_base,
  output logic                       start,
  output logic                       soft_rst,
  input  logic [CONF_NUM_KERNEL-1:0] kernel_done
);

  localparam int unsigned SR_CNT_W = $clog2(SOFT_RST_CYCLES + 1);

  logic                    r_rdy_en;
  logic                    r_aw_held;
  logic [DEC_W-1:0]        r_awaddr;
  logic                    r_w_held;
  logic [AXIL_DW-1:0]      r_wdata;
  logic                    r_bvalid;
  logic [1:0]              r_bresp;
  logic [7:0]              r_ctrl;
  logic [AXIL_DW-1:0]      r_row_num;
  logic [AXIL_DW-1:0]      r_vec_base;
  logic                    r_start;
  logic                    r_soft_rst;
  logic [SR_CNT_W-1:0]     r_sr_cnt;
  logic                    r_rvalid;
  logic [AXIL_DW-1:0]      r_rdata;
  logic [1:0]              r_rresp;
  logic                    r_busy;
  logic                    r_done;
  logic [CONF_NUM_KERNEL-1:0] r_mask;
  logic [AXIL_DW-1:0]      r_cycle_cnt;

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_ar_hs;
  logic                    w_commit;
  logic                    w_wr_ctrl;
  logic                    w_wr_row;
  logic                    w_wr_vec;
  logic                    w_key;
  logic                    w_fire;
  logic [7:0]              w_mask8;
  logic [AXIL_DW-1:0]      w_rd_data;
  logic                    w_rd_ok;
  logic                    w_unused;

  assign s_axil_awready = r_rdy_en & ~r_aw_held;
  assign s_axil_wready  = r_rdy_en & ~r_w_held;
  assign s_axil_arready = r_rdy_en & ~r_rvalid;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = r_rresp;
  assign cfg_mode       = r_ctrl[7:1];
  assign cfg_row_num    = r_row_num;
  assign cfg_vec_base   = r_vec_base;
  assign start          = r_start;
  assign soft_rst       = r_soft_rst;

  assign w_aw_hs   = s_axil_awvalid & s_axil_awready;
  assign w_w_hs    = s_axil_wvalid & s_axil_wready;
  assign w_ar_hs   = s_axil_arvalid & s_axil_arready;
  assign w_commit  = r_aw_held & r_w_held & ~r_bvalid;
  assign w_wr_ctrl = (r_awaddr == REG_CTRL);
  assign w_wr_row  = (r_awaddr == REG_ROW_NUM);
  assign w_wr_vec  = (r_awaddr == REG_VEC_BASE);
  assign w_key     = w_commit & w_wr_ctrl & (r_wdata == SOFT_RST_KEY);
  // Start is suppressed for the whole soft-reset window.
  assign w_fire    = w_commit & w_wr_vec & r_ctrl[0] & ~r_soft_rst;
  assign w_mask8   = 8'(r_mask);
  assign w_unused  = ^{s_axil_awaddr[AXIL_AW-1:DEC_W], s_axil_araddr[AXIL_AW-1:DEC_W]};

  // Write channel: independent AW/W capture, commit, B response, soft-reset pulse.
  always_ff @(posedge axil_clk or posedge rst) begin
    if (rst) begin
      r_rdy_en   <= 1'b0;
      r_aw_held  <= 1'b0;
      r_awaddr   <= '0;
      r_w_held   <= 1'b0;
      r_wdata    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_ctrl     <= '0;
      r_row_num  <= '0;
      r_vec_base <= '0;
      r_start    <= 1'b0;
      r_soft_rst <= 1'b0;
      r_sr_cnt   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_start  <= w_fire;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axil_awaddr[DEC_W-1:0];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axil_wdata;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= (w_wr_ctrl | w_wr_row | w_wr_vec) ? RESP_OKAY : RESP_SLVERR;
        if (w_wr_ctrl && !w_key) r_ctrl <= r_wdata[7:0];
        if (w_wr_row) r_row_num <= r_wdata;
        if (w_wr_vec) r_vec_base <= r_wdata;
      end else if (r_bvalid && s_axil_bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_key) begin
        r_ctrl     <= '0;
        r_row_num  <= '0;
        r_vec_base <= '0;
        r_soft_rst <= 1'b1;
        r_sr_cnt   <= SR_CNT_W'(SOFT_RST_CYCLES - 1);
      end else if (r_soft_rst) begin
        if (r_sr_cnt == '0) r_soft_rst <= 1'b0;
        else                r_sr_cnt   <= r_sr_cnt - SR_CNT_W'(1);
      end
    end
  end

  // Read decode from live register state, so a colliding commit is not yet visible.
  always_comb begin
    w_rd_data = '0;
    w_rd_ok   = 1'b1;
    case (s_axil_araddr[DEC_W-1:0])
      REG_CTRL:      w_rd_data = {24'b0, r_ctrl};
      REG_ROW_NUM:   w_rd_data = r_row_num;
      REG_VEC_BASE:  w_rd_data = r_vec_base;
      REG_STATUS:    w_rd_data = {16'b0, w_mask8, 6'b0, r_done, r_busy};
      REG_CYCLE_CNT: w_rd_data = r_cycle_cnt;
      default:       w_rd_ok   = 1'b0;
    endcase
  end

  // Read channel: single-cycle latency, response held until rready.
  always_ff @(posedge axil_clk or posedge rst) begin
    if (rst) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_rvalid && s_axil_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // Done tracker: accumulates kernel completions and busy cycles after each start.
  always_ff @(posedge axil_clk or posedge rst) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mask      <= '0;
      r_cycle_cnt <= '0;
    end else if (w_key) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mask      <= '0;
      r_cycle_cnt <= '0;
    end else if (r_start) begin
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_mask      <= '0;
      r_cycle_cnt <= '0;
    end else if (r_busy) begin
      r_mask <= r_mask | kernel_done;
      if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + AXIL_DW'(1);
      if (&r_mask) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spmv_axil_ctrl_slave.sv
// Directed self-checking bench for spmv_axil_ctrl_slave.
module tb_spmv_axil_ctrl_slave;

  logic        clk;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata, row_num, vec_base;
  logic [1:0]  bresp, rresp;
  logic [6:0]  mode;
  logic        start_o, soft_rst_o;
  logic [3:0]  kd;

  int n_assert = 0;
  int n_fail   = 0;

  spmv_axil_ctrl_slave #(.CONF_NUM_KERNEL(4), .SOFT_RST_CYCLES(16)) dut (
    .axil_clk(clk), .rst(rst),
    .s_axil_awvalid(awvalid), .s_axil_awaddr(awaddr), .s_axil_awready(awready),
    .s_axil_wvalid(wvalid), .s_axil_wdata(wdata), .s_axil_wready(wready),
    .s_axil_bvalid(bvalid), .s_axil_bresp(bresp), .s_axil_bready(bready),
    .s_axil_arvalid(arvalid), .s_axil_araddr(araddr), .s_axil_arready(arready),
    .s_axil_rvalid(rvalid), .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rready(rready),
    .cfg_mode(mode), .cfg_row_num(row_num), .cfg_vec_base(vec_base),
    .start(start_o), .soft_rst(soft_rst_o), .kernel_done(kd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // AW and W in the same cycle; returns bresp and the start level seen alongside bvalid.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          output logic [1:0] resp, output logic st);
    awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 10 && !bvalid; i++) tick();
    chk("wr_bvalid", 32'(bvalid), 32'd1);
    resp = bresp; st = start_o;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    arvalid = 1'b1; araddr = a;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 10 && !rvalid; i++) tick();
    chk("rd_rvalid", 32'(rvalid), 32'd1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rsp;
    logic [31:0] rd;
    logic        st;
    int          n;
    logic        saw_start;

    rst = 1'b1; awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; bready = 0;
    arvalid = 0; araddr = 0; rready = 0; kd = '0;
    tick(); tick();
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_outs", {start_o, soft_rst_o, bvalid, rvalid, mode}, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_rdy", {29'd0, awready, wready, arready}, 32'h7);

    // AW one cycle ahead of W
    awvalid = 1'b1; awaddr = 32'h0;
    tick();
    awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h2B;
    chk("aw_first_awready", 32'(awready), 0);
    tick();
    wvalid = 1'b0;
    chk("aw_first_no_b_yet", 32'(bvalid), 0);
    tick();
    chk("aw_first_bvalid", 32'(bvalid), 1);
    chk("aw_first_bresp", 32'(bresp), 0);
    chk("cfg_mode", 32'(mode), 32'h15);
    bready = 1'b1; tick(); bready = 1'b0;
    chk("aw_first_b_done", 32'(bvalid), 0);

    // W one cycle ahead of AW
    wvalid = 1'b1; wdata = 32'h10;
    tick();
    wvalid = 1'b0; awvalid = 1'b1; awaddr = 32'h4;
    chk("w_first_no_b", 32'(bvalid), 0);
    tick();
    awvalid = 1'b0;
    tick();
    chk("w_first_bvalid", 32'(bvalid), 1);
    chk("w_first_bresp", 32'(bresp), 0);
    chk("w_first_row", row_num, 32'h10);
    bready = 1'b1; tick(); bready = 1'b0;
    tick(); tick();
    chk("w_first_single_b", 32'(bvalid), 0);

    // AW and W together (upper address bits ignored)
    do_write(32'hFF00_0004, 32'h10, rsp, st);
    chk("same_cyc_bresp", 32'(rsp), 0);
    chk("same_cyc_row", row_num, 32'h10);
    tick();
    chk("same_cyc_single_b", 32'(bvalid), 0);

    // Start with CTRL enable set, staggered kernel completions
    do_write(32'h8, 32'hA000, rsp, st);
    chk("vec_bresp", 32'(rsp), 0);
    chk("start_pulse", 32'(st), 1);
    chk("start_one_cycle", 32'(start_o), 0);
    chk("vec_base", vec_base, 32'hA000);
    kd = 4'h1; tick(); kd = 4'h0; tick();
    kd = 4'h2; tick(); kd = 4'h0; tick();
    kd = 4'h4; tick(); kd = 4'h0;
    do_read(32'hC, rd, rsp);
    chk("status_partial", rd, 32'h0701);
    kd = 4'h8; tick(); kd = 4'h0; tick();
    do_read(32'hC, rd, rsp);
    chk("status_done", rd, 32'h0F02);
    chk("status_rresp", 32'(rsp), 0);
    do_read(32'h10, rd, rsp);
    chk("cycle_cnt_nonzero", 32'(rd != 0), 1);

    // Soft-reset key while busy
    do_write(32'h8, 32'hB000, rsp, st);
    chk("restart_pulse", 32'(st), 1);
    do_read(32'hC, rd, rsp);
    chk("status_busy", rd, 32'h0001);
    awvalid = 1'b1; awaddr = 32'h0; wvalid = 1'b1; wdata = 32'hAA;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("key_no_srst_yet", 32'(soft_rst_o), 0);
    tick();
    chk("key_bvalid", 32'(bvalid), 1);
    chk("key_bresp", 32'(bresp), 0);
    bready = 1'b1;
    n = 0; saw_start = 1'b0;
    while (soft_rst_o && n < 40) begin
      n++;
      saw_start |= start_o;
      tick();
      bready = 1'b0;
    end
    chk("soft_rst_len", 32'(n), 32'd16);
    chk("no_start_in_srst", 32'(saw_start), 0);
    chk("srst_cfg", {mode, 25'd0} | row_num | vec_base, 0);
    do_read(32'hC, rd, rsp);
    chk("srst_status", rd, 0);
    do_read(32'h0, rd, rsp);
    chk("srst_ctrl", rd, 0);
    do_read(32'h10, rd, rsp);
    chk("srst_cycle_cnt", rd, 0);

    // Unmapped read, read-only write
    do_read(32'h20, rd, rsp);
    chk("unmapped_rdata", rd, 0);
    chk("unmapped_rresp", 32'(rsp), 32'h2);
    do_write(32'hC, 32'hFFFF, rsp, st);
    chk("ro_bresp", 32'(rsp), 32'h2);
    do_read(32'hC, rd, rsp);
    chk("ro_status_same", rd, 0);

    // Back-pressured B: second transaction captured but not committed
    awvalid = 1'b1; awaddr = 32'h4; wvalid = 1'b1; wdata = 32'h55;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("bp_bvalid", 32'(bvalid), 1);
    awvalid = 1'b1; awaddr = 32'h4; wvalid = 1'b1; wdata = 32'h66;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("bp_bvalid_held", 32'(bvalid), 1);
    chk("bp_no_2nd_commit", row_num, 32'h55);
    bready = 1'b1; tick(); bready = 1'b0;
    chk("bp_b_released", 32'(bvalid), 0);
    tick();
    chk("bp_2nd_bvalid", 32'(bvalid), 1);
    chk("bp_2nd_row", row_num, 32'h66);
    bready = 1'b1; tick(); bready = 1'b0;

    // Reset with AW held and R pending
    awvalid = 1'b1; awaddr = 32'h4; arvalid = 1'b1; araddr = 32'h4;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_rvalid", 32'(rvalid), 1);
    chk("pre_rst_aw_held", 32'(awready), 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_all", {27'd0, awready, wready, arready, bvalid, rvalid}, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("after_rst_rdy", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'h1C);
    wvalid = 1'b1; wdata = 32'h77;
    tick();
    wvalid = 1'b0;
    tick(); tick();
    chk("no_stale_b", 32'(bvalid), 0);
    chk("no_stale_r", 32'(rvalid), 0);
    chk("no_stale_commit", row_num, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
